// File: rtl/prescaler_bank.sv
// Multi-channel programmable clock prescaler: each channel divides i_Clk by a
// runtime divisor and produces a tick pulse, a square wave and a one-shot done flag.
module prescaler_bank #(
  parameter int N_CH    = 4,
  parameter int W       = 20,
  parameter int DIV_RST = 100000,
  parameter int SEL_W   = 2
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_En,
  input  logic              i_Wr,
  input  logic [SEL_W-1:0]  i_Sel,
  input  logic [W-1:0]      i_Div,
  input  logic              i_Mode,
  input  logic [N_CH-1:0]   i_Clr,
  output logic [N_CH-1:0]   o_Tick,
  output logic [N_CH-1:0]   o_Sq,
  output logic [N_CH-1:0]   o_Done,
  output logic [2*N_CH-1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [W-1:0] DIV_INIT = W'(DIV_RST);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    localparam logic [SEL_W-1:0] K_SEL = SEL_W'(k);

    state_t       state_r;
    logic [W-1:0] div_r;
    logic [W-1:0] cnt_r;
    logic         mode_r;
    logic         tick_r;
    logic         sq_r;
    logic         done_r;
    logic         wr_hit;
    logic         at_term;

    // Out-of-range selects match no channel, so such writes fall through untouched.
    assign wr_hit  = i_Wr && (i_Sel == K_SEL);
    assign at_term = (cnt_r == div_r - W'(1));

    // Per-channel priority on one edge: write, then clear, then counting.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
        state_r <= RUN;
        div_r   <= DIV_INIT;
        cnt_r   <= '0;
        mode_r  <= 1'b0;
        tick_r  <= 1'b0;
        sq_r    <= 1'b0;
        done_r  <= 1'b0;
      end else if (wr_hit) begin
        div_r   <= i_Div;
        mode_r  <= i_Mode;
        cnt_r   <= '0;
        tick_r  <= 1'b0;
        sq_r    <= 1'b0;
        done_r  <= 1'b0;
        state_r <= (i_Div != '0) ? RUN : IDLE;
      end else if (i_Clr[k]) begin
        cnt_r   <= '0;
        tick_r  <= 1'b0;
        sq_r    <= 1'b0;
        done_r  <= 1'b0;
        state_r <= (div_r != '0) ? RUN : IDLE;
      end else if (i_En) begin
        tick_r <= 1'b0;
        case (state_r)
          RUN: begin
            if (at_term) begin
              cnt_r  <= '0;
              tick_r <= 1'b1;
              sq_r   <= ~sq_r;
              if (mode_r) begin
                state_r <= DONE;
                done_r  <= 1'b1;
              end
            end else begin
              cnt_r <= cnt_r + W'(1);
            end
          end
          default: cnt_r <= '0;
        endcase
      end else begin
        tick_r <= 1'b0;
      end
    end

    assign o_Tick[k]          = tick_r;
    assign o_Sq[k]            = sq_r;
    assign o_Done[k]          = done_r;
    assign dbg_state[2*k +: 2] = state_r;
  end

endmodule

// File: tb/tb_prescaler_bank.sv
// Self-checking bench for prescaler_bank: directed scenarios then random traffic,
// every cycle compared against a behavioural per-channel period model.
module tb_prescaler_bank;
  localparam int N_CH    = 3;
  localparam int W       = 8;
  localparam int DIV_RST = 10;
  localparam int SEL_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              wr;
  logic [SEL_W-1:0]  sel;
  logic [W-1:0]      div_in;
  logic              mode_in;
  logic [N_CH-1:0]   clr;
  logic [N_CH-1:0]   tick;
  logic [N_CH-1:0]   sq;
  logic [N_CH-1:0]   done;
  logic [2*N_CH-1:0] dbg_state;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model: each channel is "div", "mode", enabled edges elapsed in the
  // current period, and whether it is counting, stopped (div 0) or finished.
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
  int m_div [N_CH];
  int m_mode[N_CH];
  int m_el  [N_CH];
  int m_st  [N_CH];
  logic [N_CH-1:0] m_tick, m_sq, m_done;

  prescaler_bank #(.N_CH(N_CH), .W(W), .DIV_RST(DIV_RST), .SEL_W(SEL_W)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_En(en), .i_Wr(wr), .i_Sel(sel), .i_Div(div_in),
    .i_Mode(mode_in), .i_Clr(clr), .o_Tick(tick), .o_Sq(sq), .o_Done(done),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_CH; k++) begin
      m_div[k] = DIV_RST; m_mode[k] = 0; m_el[k] = 0; m_st[k] = M_RUN;
    end
    m_tick = '0; m_sq = '0; m_done = '0;
  endtask

  task automatic model_step();
    for (int k = 0; k < N_CH; k++) begin
      m_tick[k] = 1'b0;
      if (wr && int'(sel) == k) begin
        m_div[k] = int'(div_in); m_mode[k] = int'(mode_in); m_el[k] = 0;
        m_sq[k] = 1'b0; m_done[k] = 1'b0;
        m_st[k] = (div_in != 0) ? M_RUN : M_IDLE;
      end else if (clr[k]) begin
        m_el[k] = 0; m_sq[k] = 1'b0; m_done[k] = 1'b0;
        m_st[k] = (m_div[k] != 0) ? M_RUN : M_IDLE;
      end else if (en && m_st[k] == M_RUN) begin
        if (m_el[k] + 1 == m_div[k]) begin
          m_el[k] = 0; m_tick[k] = 1'b1; m_sq[k] = ~m_sq[k];
          if (m_mode[k] == 1) begin
            m_st[k] = M_DONE; m_done[k] = 1'b1;
          end
        end else begin
          m_el[k] = m_el[k] + 1;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".tick"}, 32'(tick), 32'(m_tick));
    check({tag, ".sq"},   32'(sq),   32'(m_sq));
    check({tag, ".done"}, 32'(done), 32'(m_done));
  endtask

  // One clock: model consumes the inputs present at the edge, outputs checked 1ns later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic write_ch(input int ch, input int d, input logic m);
    wr = 1'b1; sel = SEL_W'(ch); div_in = W'(d); mode_in = m;
    cycle("wr");
    wr = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; wr = 1'b0; sel = '0; div_in = '0; mode_in = 1'b0; clr = '0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    run("free_run", 45);

    write_ch(1, 3, 1'b0);
    write_ch(2, 1, 1'b0);
    run("ch1_ch2", 20);

    write_ch(0, 5, 1'b1);
    run("oneshot", 15);
    clr = 3'b001;
    cycle("clr0");
    clr = '0;
    run("oneshot2", 15);

    write_ch(1, 4, 1'b0);
    run("en_pre", 2);
    en = 1'b0;
    run("en_low", 3);
    en = 1'b1;
    run("en_post", 10);
    write_ch(1, 0, 1'b0);
    run("stopped", 8);
    write_ch(3, 2, 1'b1);
    run("bad_sel", 6);

    // Collide a write plus clear with ch2's terminal count.
    write_ch(2, 4, 1'b0);
    for (int i = 0; i < 20 && m_el[2] != m_div[2] - 1; i++) cycle("to_term");
    check("term_reached", 32'(m_el[2]), 32'(m_div[2] - 1));
    wr = 1'b1; sel = 2'd2; div_in = 8'd6; mode_in = 1'b0; clr = 3'b100;
    cycle("wr_clr_term");
    wr = 1'b0; clr = '0;
    run("after_wr", 8);
    for (int i = 0; i < 20 && m_el[2] != m_div[2] - 1; i++) cycle("to_term2");
    check("term2_reached", 32'(m_el[2]), 32'(m_div[2] - 1));
    clr = 3'b100;
    cycle("clr_term");
    clr = '0;
    run("after_clr", 10);

    run("pre_rst", 4);
    async_reset("async_rst");
    run("post_rst", 25);

    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      wr      = ($urandom_range(0, 19) == 0);
      sel     = SEL_W'($urandom_range(0, 3));
      div_in  = W'($urandom_range(0, 7));
      mode_in = 1'($urandom_range(0, 1));
      for (int k = 0; k < N_CH; k++) clr[k] = ($urandom_range(0, 39) == 0);
      cycle("rand");
      if ($urandom_range(0, 999) == 0) async_reset("rand_rst");
    end
    wr = 1'b0; clr = '0; en = 1'b1;
    run("tail", 10);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
